// File: rtl/f2h_uart_tx_master.sv
// f2h_uart_tx_master: sends one byte at a time to the HPS UART0 through the
// FPGA-to-HPS AXI3 slave port. Each byte polls LSR.THRE until the transmit
// holding register is empty, then writes the byte to THR. All bursts are single-beat.
module f2h_uart_tx_master #(
    parameter logic [31:0] UART_BASE = 32'hFFC02000,
    parameter int unsigned POLL_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        err,
    output logic [7:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [1:0]  m_axi_awlock,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic [4:0]  m_axi_awuser,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [7:0]  m_axi_wid,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [7:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [7:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [3:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [1:0]  m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [4:0]  m_axi_aruser,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [7:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_AR    = 3'd2;
    localparam logic [2:0] S_R     = 3'd3;
    localparam logic [2:0] S_WAITP = 3'd4;
    localparam logic [2:0] S_AW_W  = 3'd5;
    localparam logic [2:0] S_B     = 3'd6;

    localparam logic [31:0] LSR_ADDR  = UART_BASE + 32'h14;
    localparam logic [7:0]  POLL_LOAD = 8'(POLL_WAIT);

    logic [2:0] state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] cnt_q, cnt_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       err_q, err_d;

    // IDs, rlast and the LSR bits other than THRE carry nothing this master needs.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast,
                             m_axi_rdata[31:6], m_axi_rdata[4:0]};

    // Next-state logic: byte accept, LSR poll loop, THR write, response collection.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: state_d = S_AR;
            S_AR: begin
                if (m_axi_arready) state_d = S_R;
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    // A read error is recorded but the THRE bit still decides.
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (m_axi_rdata[5]) begin
                        state_d   = S_AW_W;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = S_WAITP;
                        cnt_d   = POLL_LOAD;
                    end
                end
            end
            S_WAITP: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = S_AR;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_AW_W: begin
                // AW and W complete independently; valid of each is gated by its done flag.
                if (m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            byte_q    <= 8'h00;
            cnt_q     <= 8'h00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    assign in_ready = (state_q == S_IDLE) && !reset;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;

    assign m_axi_arid    = 8'h00;
    assign m_axi_araddr  = LSR_ADDR;
    assign m_axi_arlen   = 4'h0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 2'b00;
    assign m_axi_arcache = 4'h0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_aruser  = 5'h00;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_R);

    assign m_axi_awid    = 8'h00;
    assign m_axi_awaddr  = UART_BASE;
    assign m_axi_awlen   = 4'h0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 2'b00;
    assign m_axi_awcache = 4'h0;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awuser  = 5'h00;
    assign m_axi_awvalid = (state_q == S_AW_W) && !aw_done_q;

    assign m_axi_wid     = 8'h00;
    assign m_axi_wdata   = {24'h000000, byte_q};
    assign m_axi_wstrb   = 4'b0001;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = (state_q == S_AW_W) && !w_done_q;
    assign m_axi_bready  = (state_q == S_B);

endmodule

// File: tb/tb_f2h_uart_tx_master.sv
// Testbench for f2h_uart_tx_master: AXI3 slave model with configurable ready/valid
// delays, a byte scoreboard checked on every W beat, and directed scenarios.
module tb_f2h_uart_tx_master;

    localparam logic [31:0] BASE = 32'hFFC02000;
    localparam int PW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, busy, err;
    logic [7:0]  m_axi_awid;   logic [31:0] m_axi_awaddr; logic [3:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize; logic [1:0]  m_axi_awburst; logic [1:0] m_axi_awlock;
    logic [3:0]  m_axi_awcache; logic [2:0] m_axi_awprot; logic [4:0] m_axi_awuser;
    logic        m_axi_awvalid, m_axi_awready;
    logic [7:0]  m_axi_wid;    logic [31:0] m_axi_wdata;  logic [3:0] m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid;    logic [1:0]  m_axi_bresp;  logic m_axi_bvalid, m_axi_bready;
    logic [7:0]  m_axi_arid;   logic [31:0] m_axi_araddr; logic [3:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize; logic [1:0]  m_axi_arburst; logic [1:0] m_axi_arlock;
    logic [3:0]  m_axi_arcache; logic [2:0] m_axi_arprot; logic [4:0] m_axi_aruser;
    logic        m_axi_arvalid, m_axi_arready;
    logic [7:0]  m_axi_rid;    logic [31:0] m_axi_rdata;  logic [1:0] m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    f2h_uart_tx_master #(.UART_BASE(BASE), .POLL_WAIT(PW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .err(err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of bytes accepted by the DUT, consumed on each W handshake.
    logic [7:0]  exp_q[$];
    logic [31:0] lsr_q[$];

    // Slave model knobs.
    int       ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    bit       rand_mode = 0, ar_hold = 0;
    logic [1:0] rresp_next = 2'b00, bresp_next = 2'b00;

    function automatic int pick(input int d);
        return rand_mode ? int'($urandom_range(0, 4)) : d;
    endfunction

    // AXI3 slave: handshakes observed at negedge, responses driven just after posedge.
    initial begin : slave
        int  ar_wait, r_wait, aw_wait, w_wait, b_wait;
        bit  r_pend, b_pend, aw_got, w_got;
        bit  s_ar, s_r, s_aw, s_w, s_b;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_rid = 8'h3C; m_axi_rlast = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 8'h3C;
        forever begin
            @(negedge clk);
            s_ar = m_axi_arvalid && m_axi_arready;
            s_r  = m_axi_rvalid  && m_axi_rready;
            s_aw = m_axi_awvalid && m_axi_awready;
            s_w  = m_axi_wvalid  && m_axi_wready;
            s_b  = m_axi_bvalid  && m_axi_bready;
            @(posedge clk); #1;
            if (reset) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
                m_axi_wready = 0; m_axi_bvalid = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            end else begin
                if (s_ar) begin
                    m_axi_arready = 0; r_pend = 1; r_wait = pick(r_dly);
                end else if (!m_axi_arvalid) begin
                    m_axi_arready = 0; ar_wait = pick(ar_dly);
                end else if (!ar_hold && !m_axi_arready) begin
                    if (ar_wait == 0) m_axi_arready = 1; else ar_wait--;
                end
                if (s_r) begin
                    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rdata = 0;
                end else if (r_pend && !m_axi_rvalid) begin
                    if (r_wait == 0) begin
                        m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rresp = rresp_next;
                        if (lsr_q.size() > 0) m_axi_rdata = lsr_q.pop_front();
                        else if (rand_mode && $urandom_range(0, 3) == 0) m_axi_rdata = 32'h0;
                        else m_axi_rdata = 32'h20;
                        r_pend = 0;
                    end else r_wait--;
                end
                if (s_aw) begin
                    m_axi_awready = 0; aw_got = 1;
                end else if (!m_axi_awvalid) begin
                    m_axi_awready = 0; aw_wait = pick(aw_dly);
                end else if (!m_axi_awready) begin
                    if (aw_wait == 0) m_axi_awready = 1; else aw_wait--;
                end
                if (s_w) begin
                    m_axi_wready = 0; w_got = 1;
                end else if (!m_axi_wvalid) begin
                    m_axi_wready = 0; w_wait = pick(w_dly);
                end else if (!m_axi_wready) begin
                    if (w_wait == 0) m_axi_wready = 1; else w_wait--;
                end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pend = 1; b_wait = pick(b_dly);
                end
                if (s_b) begin
                    m_axi_bvalid = 0; m_axi_bresp = 0;
                end else if (b_pend && !m_axi_bvalid) begin
                    if (b_wait == 0) begin
                        m_axi_bvalid = 1; m_axi_bresp = bresp_next; b_pend = 0;
                    end else b_wait--;
                end
            end
        end
    end

    // Protocol monitor and scoreboard consumer.
    int cyc = 0, n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
    int last_ar = -1, min_gap = 1000000;
    bit prev_arp = 0, prev_awp = 0, prev_wp = 0;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_arp = 0; prev_awp = 0; prev_wp = 0;
        end else begin
            if (prev_arp) chk("arvalid_held", m_axi_arvalid, 1);
            if (prev_awp) chk("awvalid_held", m_axi_awvalid, 1);
            if (prev_wp)  chk("wvalid_held", m_axi_wvalid, 1);
            if (m_axi_arvalid) begin
                chk("araddr", m_axi_araddr, BASE + 32'h14);
                chk("ar_ctrl", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                    m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_aruser},
                    {1'b0, 8'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0, 5'h0});
            end
            if (m_axi_awvalid) begin
                chk("awaddr", m_axi_awaddr, BASE);
                chk("aw_ctrl", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                    m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awuser},
                    {1'b0, 8'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0, 5'h0});
            end
            if (m_axi_wvalid) begin
                chk("w_ctrl", {m_axi_wid, m_axi_wstrb, m_axi_wlast}, {8'h0, 4'b0001, 1'b1});
                if (exp_q.size() > 0) chk("wdata", m_axi_wdata, {24'h0, exp_q[0]});
                else chk("wdata_unexpected", exp_q.size(), 1);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                n_ar++;
                if (last_ar >= 0 && cyc - last_ar < min_gap) min_gap = cyc - last_ar;
                last_ar = cyc;
            end
            if (m_axi_awvalid && m_axi_awready) n_aw++;
            if (m_axi_wvalid && m_axi_wready) begin
                n_w++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (m_axi_bvalid && m_axi_bready) n_b++;
            prev_arp = m_axi_arvalid && !m_axi_arready;
            prev_awp = m_axi_awvalid && !m_axi_awready;
            prev_wp  = m_axi_wvalid  && !m_axi_wready;
        end
    end

    // Offer a byte once in_ready is seen; the handshake lands on the following posedge.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 4000) begin @(negedge clk); n++; end
        chk("send_ready_timeout", in_ready, 1);
        in_data = b; in_valid = 1;
        exp_q.push_back(b);
        @(posedge clk); #1;
        if (!keep) in_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 4000) begin @(negedge clk); n++; end
        chk(tag, busy, 0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0, aw0, w0, b0, n;
        in_valid = 0; in_data = 0; reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 0);
        chk("rst_readies", {m_axi_rready, m_axi_bready}, 0);
        chk("rst_wdata_byte", m_axi_wdata, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Single byte, THRE set on first poll, AW and W accepted together.
        lsr_q.push_back(32'h60);
        a0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
        send_byte(8'h41, 0);
        @(negedge clk);
        chk("latch_arvalid", m_axi_arvalid, 0);
        chk("latch_busy", busy, 1);
        chk("latch_in_ready", in_ready, 0);
        @(negedge clk);
        chk("arvalid_n2", m_axi_arvalid, 1);
        wait_idle("t1_idle_timeout");
        chk("t1_ar_count", n_ar - a0, 1);
        chk("t1_aw_count", n_aw - aw0, 1);
        chk("t1_w_count", n_w - w0, 1);
        chk("t1_b_count", n_b - b0, 1);
        chk("t1_err", err, 0);
        chk("t1_in_ready", in_ready, 1);

        // THRE clear twice: three polls separated by the wait interval.
        lsr_q.push_back(32'h00); lsr_q.push_back(32'h00); lsr_q.push_back(32'h20);
        a0 = n_ar; w0 = n_w; last_ar = -1; min_gap = 1000000;
        send_byte(8'h55, 0);
        wait_idle("t2_idle_timeout");
        chk("t2_ar_count", n_ar - a0, 3);
        chk("t2_w_count", n_w - w0, 1);
        chk("t2_poll_gap", min_gap >= PW, 1);

        // W accepted five cycles ahead of AW.
        aw_dly = 5; w_dly = 0;
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        send_byte(8'h5A, 0);
        n = 0;
        @(negedge clk);
        while (!(m_axi_wvalid && m_axi_wready) && n < 200) begin @(negedge clk); n++; end
        chk("t3_w_hs_seen", m_axi_wvalid && m_axi_wready, 1);
        @(negedge clk);
        chk("t3_wvalid_dropped", m_axi_wvalid, 0);
        chk("t3_awvalid_held", m_axi_awvalid, 1);
        wait_idle("t3_idle_timeout");
        chk("t3_aw_count", n_aw - aw0, 1);
        chk("t3_w_count", n_w - w0, 1);
        chk("t3_b_count", n_b - b0, 1);
        aw_dly = 0;

        // Read error: recorded, write still happens.
        rresp_next = 2'b10; w0 = n_w;
        send_byte(8'h11, 0);
        wait_idle("t4_idle_timeout");
        rresp_next = 2'b00;
        chk("t4_rd_err", err, 1);
        chk("t4_w_count", n_w - w0, 1);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("t4_err_cleared", err, 0);
        @(posedge clk); #1 reset = 0;

        // Write error is sticky across later good transfers.
        bresp_next = 2'b10; w0 = n_w;
        send_byte(8'h77, 0);
        wait_idle("t5_idle_timeout");
        bresp_next = 2'b00;
        chk("t5_wr_err", err, 1);
        chk("t5_in_ready", in_ready, 1);
        send_byte(8'h78, 0);
        wait_idle("t5b_idle_timeout");
        chk("t5_err_sticky", err, 1);
        chk("t5_w_count", n_w - w0, 2);

        // Reset while AR is stalled.
        ar_hold = 1;
        send_byte(8'h33, 0);
        n = 0;
        @(negedge clk);
        while (!m_axi_arvalid && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("t6_arvalid_stalled", m_axi_arvalid, 1);
        #2 reset = 1;
        #1;
        chk("t6_arvalid_async", m_axi_arvalid, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_in_ready_rst", in_ready, 0);
        exp_q.delete();
        ar_hold = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t6_in_ready_release", in_ready, 1);
        chk("t6_err_cleared", err, 0);
        a0 = n_ar; w0 = n_w;
        send_byte(8'hA5, 0);
        wait_idle("t6_idle_timeout");
        chk("t6_ar_count", n_ar - a0, 1);
        chk("t6_w_count", n_w - w0, 1);
        chk("t6_err", err, 0);

        // Back-to-back stream with random slave timing.
        rand_mode = 1; w0 = n_w;
        for (int i = 0; i < 16; i++) send_byte(8'(i), i != 15);
        wait_idle("t7_idle_timeout");
        rand_mode = 0;
        chk("t7_w_count", n_w - w0, 16);
        chk("t7_scoreboard_empty", exp_q.size(), 0);
        chk("t7_err", err, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
